// File: rtl/as_gpio_port.sv
// as_gpio_port: memory-mapped GPIO controller.
//
// Holds the ID, direction and output registers, synchronises pad inputs with
// sticky rising-edge capture, and generates a counted chip-select strobe.
//
// Ports:
//   clk_i      system clock, all state changes on the rising edge
//   rst_i      synchronous active-high reset
//   stb_i      bus transaction request
//   we_i       1 = write, 0 = read (sampled with stb_i)
//   addr_i     register select
//   wdata_i    write data
//   rdata_o    registered read data, valid while ack_o = 1
//   ack_o      one-cycle transaction acknowledge
//   gpio_i     pad input values
//   gpio_o     pad output values
//   gpio_oe_o  pad output enables, 1 = drive
//   cs_o       chip-select / data-valid strobe
//   irq_o      OR of all sticky rise bits
//
// Register map: 0 ID, 1 DIR, 2 OUT, 3 IN, 4 RISE (W1C), 5 CS, others read 0.
module as_gpio_port #(
  parameter int unsigned nr_gpios        = 8,
  parameter int unsigned gpio_addr_width = 3,
  parameter logic [63:0] GPIO_ID         = 64'h81
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stb_i,
  input  logic                       we_i,
  input  logic [gpio_addr_width-1:0] addr_i,
  input  logic [63:0]                wdata_i,
  output logic [63:0]                rdata_o,
  output logic                       ack_o,
  input  logic [nr_gpios-1:0]        gpio_i,
  output logic [nr_gpios-1:0]        gpio_o,
  output logic [nr_gpios-1:0]        gpio_oe_o,
  output logic                       cs_o,
  output logic                       irq_o
);

  localparam logic [gpio_addr_width-1:0] AddrId   = gpio_addr_width'(0);
  localparam logic [gpio_addr_width-1:0] AddrDir  = gpio_addr_width'(1);
  localparam logic [gpio_addr_width-1:0] AddrOut  = gpio_addr_width'(2);
  localparam logic [gpio_addr_width-1:0] AddrIn   = gpio_addr_width'(3);
  localparam logic [gpio_addr_width-1:0] AddrRise = gpio_addr_width'(4);
  localparam logic [gpio_addr_width-1:0] AddrCs   = gpio_addr_width'(5);

  typedef enum logic [0:0] {StIdle, StAck} state_t;

  state_t              state;
  state_t              state_next;
  logic [nr_gpios-1:0] dir_reg;
  logic [nr_gpios-1:0] out_reg;
  logic [nr_gpios-1:0] sync1;
  logic [nr_gpios-1:0] sync2;
  logic [nr_gpios-1:0] sync2_d;
  logic [nr_gpios-1:0] rise;
  logic [nr_gpios-1:0] rise_set;
  logic [nr_gpios-1:0] rise_clr;
  logic [nr_gpios-1:0] wmask;
  logic [7:0]          cs_cnt;
  logic [63:0]         rd_val;
  logic                accept;
  logic                wr_en;
  logic                rd_en;
  logic                unused_wdata;

  // A transaction is only accepted from IDLE; the ACK cycle ignores stb_i.
  assign accept = (state == StIdle) && stb_i;
  assign wr_en  = accept && we_i;
  assign rd_en  = accept && !we_i;
  assign wmask  = wdata_i[nr_gpios-1:0];

  // Upper write bits are architecturally ignored.
  assign unused_wdata = ^wdata_i;

  // ---------------------------------------------------------------------------
  // Bus FSM: state register, next-state logic, output logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      StIdle:  if (stb_i) state_next = StAck;
      StAck:   state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  always_comb begin
    ack_o = (state == StAck);
  end

  // ---------------------------------------------------------------------------
  // Read mux; unused upper bits stay 0
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    case (addr_i)
      AddrId:   rd_val                 = GPIO_ID;
      AddrDir:  rd_val[nr_gpios-1:0]   = dir_reg;
      AddrOut:  rd_val[nr_gpios-1:0]   = out_reg;
      AddrIn:   rd_val[nr_gpios-1:0]   = sync2;
      AddrRise: rd_val[nr_gpios-1:0]   = rise;
      AddrCs:   rd_val[7:0]            = cs_cnt;
      default:  rd_val                 = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (rd_en) begin
      rdata_o <= rd_val;
    end
  end

  // ---------------------------------------------------------------------------
  // DIR / OUT registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dir_reg <= '0;
      out_reg <= '0;
    end else if (wr_en) begin
      if (addr_i == AddrDir) dir_reg <= wmask;
      if (addr_i == AddrOut) out_reg <= wmask;
    end
  end

  assign gpio_oe_o = dir_reg;
  assign gpio_o    = out_reg;

  // ---------------------------------------------------------------------------
  // Input synchroniser and sticky rising-edge capture
  // ---------------------------------------------------------------------------
  assign rise_set = sync2 & ~sync2_d;
  assign rise_clr = (wr_en && (addr_i == AddrRise)) ? wmask : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
      rise    <= '0;
    end else begin
      sync1   <= gpio_i;
      sync2   <= sync1;
      sync2_d <= sync2;
      // Set is OR-ed in after the clear so a coincident edge is never lost.
      rise    <= (rise & ~rise_clr) | rise_set;
    end
  end

  assign irq_o = |rise;

  // ---------------------------------------------------------------------------
  // CS generator: a write reloads the counter, even mid-pulse; 0 stops it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_cnt <= '0;
    end else if (wr_en && (addr_i == AddrCs)) begin
      cs_cnt <= wdata_i[7:0];
    end else if (cs_cnt != 8'd0) begin
      cs_cnt <= cs_cnt - 8'd1;
    end
  end

  assign cs_o = (cs_cnt != 8'd0);

endmodule

// File: tb/tb_as_gpio_port.sv
// Self-checking bench for as_gpio_port with the default parameters.
module tb_as_gpio_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [2:0]  addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ack;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        cs;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state
  logic [7:0]  m_dir;
  logic [7:0]  m_out;
  logic [7:0]  m_in;

  always #5 clk = ~clk;

  as_gpio_port dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .stb_i     (stb),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .ack_o     (ack),
    .gpio_i    (gpio_in),
    .gpio_o    (gpio_out),
    .gpio_oe_o (gpio_oe),
    .cs_o      (cs),
    .irq_o     (irq)
  );

  // One complete transaction, starting and ending at a falling edge.
  task automatic bus(input logic w, input logic [2:0] a, input logic [63:0] d,
                     output logic got_ack, output logic [63:0] got_rd);
    stb = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
    got_ack = ack;
    got_rd  = rdata;
    stb = 1'b0; we = 1'b0; wdata = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stb   = ~stb;
      we    = 1'($urandom_range(0, 1));
      addr  = 3'($urandom_range(0, 7));
      wdata = {$urandom, $urandom};
      @(negedge clk);
      n_cmp++;
      if ({ack, cs, irq, gpio_out, gpio_oe, rdata} !== 83'd0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc %0d: ack=%b cs=%b irq=%b gpio_o=%h oe=%h rdata=%h, want 0",
                 i, ack, cs, irq, gpio_out, gpio_oe, rdata);
      end
    end
    stb = 1'b0; we = 1'b0; rst = 1'b0;
    m_dir = '0; m_out = '0; m_in = '0;
    // First ID read after reset
    stb = 1'b1; addr = 3'd0;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b1 || rdata !== 64'h81) begin
      n_bad++;
      $display("FAIL reset_id_read: ack=%b rdata=%h, want ack=1 rdata=81", ack, rdata);
    end
    stb = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ack_width: ack=%b, want 0", ack);
    end
  endtask

  task automatic test_dir_out();
    logic        a;
    logic [63:0] r;
    bus(1'b1, 3'd1, 64'h7F, a, r);
    m_dir = 8'h7F;
    n_cmp++;
    if (a !== 1'b1 || gpio_oe !== m_dir) begin
      n_bad++;
      $display("FAIL dir_write: ack=%b oe=%h, want ack=1 oe=%h", a, gpio_oe, m_dir);
    end
    bus(1'b1, 3'd2, 64'h1FF, a, r);
    m_out = 8'hFF;
    n_cmp++;
    if (a !== 1'b1 || gpio_out !== m_out) begin
      n_bad++;
      $display("FAIL out_write: ack=%b gpio_o=%h, want ack=1 gpio_o=%h", a, gpio_out, m_out);
    end
    bus(1'b0, 3'd1, 64'h0, a, r);
    n_cmp++;
    if (r !== 64'h7F) begin
      n_bad++;
      $display("FAIL dir_readback: got %h want 7f", r);
    end
    bus(1'b0, 3'd2, 64'h0, a, r);
    n_cmp++;
    if (r !== 64'hFF) begin
      n_bad++;
      $display("FAIL out_readback: got %h want ff", r);
    end
    bus(1'b1, 3'd6, '1, a, r);
    bus(1'b0, 3'd6, 64'h0, a, r);
    n_cmp++;
    if (r !== 64'h0) begin
      n_bad++;
      $display("FAIL addr6_read: got %h want 0", r);
    end
  endtask

  task automatic test_input_edge();
    logic        a;
    logic [63:0] r;
    gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    gpio_in[7] = 1'b1;
    m_in = 8'h80;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_early: irq=%b want 0 one edge after sync2", irq);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_set: irq=%b want 1", irq);
    end
    bus(1'b0, 3'd3, 64'h0, a, r);
    n_cmp++;
    if (r !== {56'd0, m_in}) begin
      n_bad++;
      $display("FAIL in_read: got %h want %h", r, m_in);
    end
    bus(1'b0, 3'd4, 64'h0, a, r);
    n_cmp++;
    if (r !== 64'h80) begin
      n_bad++;
      $display("FAIL rise_read: got %h want 80", r);
    end
    bus(1'b1, 3'd4, 64'h80, a, r);
    bus(1'b0, 3'd4, 64'h0, a, r);
    n_cmp++;
    if (r !== 64'h0 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL rise_w1c: rise=%h irq=%b want 0/0", r, irq);
    end
    // New edge whose set lands on the same edge as a W1C of that bit.
    gpio_in[7] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[7] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = 3'd4; wdata = 64'h80;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b1) begin
      n_bad++;
      $display("FAIL w1c_collide_ack: ack=%b want 1", ack);
    end
    stb = 1'b0; we = 1'b0; wdata = '0;
    @(negedge clk);
    bus(1'b0, 3'd4, 64'h0, a, r);
    n_cmp++;
    if (r !== 64'h80 || irq !== 1'b1) begin
      n_bad++;
      $display("FAIL set_wins_over_clear: rise=%h irq=%b want 80/1", r, irq);
    end
    bus(1'b1, 3'd4, 64'hFF, a, r);
  endtask

  task automatic test_random_regs();
    logic        a;
    logic [63:0] r;
    logic [63:0] d;
    logic [63:0] exp;
    logic [2:0]  sel;
    logic [2:0]  ign [4];
    int          op;
    ign = '{3'd0, 3'd3, 3'd6, 3'd7};
    gpio_in = 8'($urandom);
    m_in = gpio_in;
    repeat (5) @(negedge clk);
    bus(1'b1, 3'd4, 64'hFF, a, r);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      d  = {$urandom, $urandom};
      exp = '0;
      case (op)
        0: begin bus(1'b1, 3'd1, d, a, r); m_dir = d[7:0]; end
        1: begin bus(1'b1, 3'd2, d, a, r); m_out = d[7:0]; end
        2: begin sel = ign[$urandom_range(0, 3)]; bus(1'b1, sel, d, a, r); end
        default: begin
          sel = 3'($urandom_range(0, 7));
          bus(1'b0, sel, 64'h0, a, r);
          case (sel)
            3'd0: exp = 64'h81;
            3'd1: exp = {56'd0, m_dir};
            3'd2: exp = {56'd0, m_out};
            3'd3: exp = {56'd0, m_in};
            default: exp = 64'h0;
          endcase
          n_cmp++;
          if (r !== exp) begin
            n_bad++;
            $display("FAIL rand_read it %0d addr %0d: got %h want %h", i, sel, r, exp);
          end
        end
      endcase
      n_cmp++;
      if (a !== 1'b1 || gpio_out !== m_out || gpio_oe !== m_dir) begin
        n_bad++;
        $display("FAIL rand_state it %0d: ack=%b gpio_o=%h oe=%h want 1/%h/%h",
                 i, a, gpio_out, gpio_oe, m_out, m_dir);
      end
    end
  endtask

  task automatic test_cs_pulse();
    logic        a;
    logic [63:0] r;
    int          ns[$];
    int          highs;
    int          cs_end;
    logic        exp;
    bus(1'b1, 3'd2, 64'h81, a, r);
    m_out = 8'h81;
    ns = {3, 0, 1, 7};
    for (int i = 0; i < 4; i++) ns.push_back($urandom_range(0, 15));
    foreach (ns[t]) begin
      highs = 0;
      stb = 1'b1; we = 1'b1; addr = 3'd5;
      wdata = {$urandom, $urandom};
      wdata[7:0] = 8'(ns[t]);
      for (int j = 0; j < ns[t] + 4; j++) begin
        @(negedge clk);
        if (j == 0) begin stb = 1'b0; we = 1'b0; end
        exp = (j < ns[t]);
        if (cs === 1'b1) highs++;
        n_cmp++;
        if (cs !== exp || (cs === 1'b1 && gpio_out !== m_out)) begin
          n_bad++;
          $display("FAIL cs_pulse N=%0d j=%0d: cs=%b gpio_o=%h want cs=%b gpio_o=%h",
                   ns[t], j, cs, gpio_out, exp, m_out);
        end
      end
      n_cmp++;
      if (highs != ns[t]) begin
        n_bad++;
        $display("FAIL cs_length N=%0d: got %0d high cycles want %0d", ns[t], highs, ns[t]);
      end
    end
    // Remaining count, then stop with N = 0.
    bus(1'b1, 3'd5, 64'd10, a, r);
    bus(1'b0, 3'd5, 64'd0, a, r);
    n_cmp++;
    if (r !== 64'd9) begin
      n_bad++;
      $display("FAIL cs_remaining: got %0d want 9", r);
    end
    bus(1'b1, 3'd5, 64'd0, a, r);
    n_cmp++;
    if (cs !== 1'b0) begin
      n_bad++;
      $display("FAIL cs_stop: cs=%b want 0", cs);
    end
    // Retrigger: 5 then 2 two cycles later.
    highs = 0;
    cs_end = 5;
    stb = 1'b1; we = 1'b1; addr = 3'd5; wdata = 64'd5;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 0) begin stb = 1'b0; we = 1'b0; end
      if (j == 1) begin stb = 1'b1; we = 1'b1; wdata = 64'd2; end
      if (j == 2) begin stb = 1'b0; we = 1'b0; cs_end = 2 + 2; end
      exp = (j < cs_end);
      if (cs === 1'b1) highs++;
      n_cmp++;
      if (cs !== exp) begin
        n_bad++;
        $display("FAIL cs_retrigger j=%0d: cs=%b want %b", j, cs, exp);
      end
    end
    n_cmp++;
    if (highs != 4) begin
      n_bad++;
      $display("FAIL cs_retrigger_len: got %0d high cycles want 4", highs);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic        a;
    logic [63:0] r;
    bus(1'b1, 3'd5, 64'd200, a, r);
    repeat (9) @(negedge clk);
    n_cmp++;
    if (cs !== 1'b1) begin
      n_bad++;
      $display("FAIL cs_long_pulse: cs=%b want 1", cs);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_dir = '0; m_out = '0;
    n_cmp++;
    if ({cs, ack, gpio_out, gpio_oe} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_mid_pulse: cs=%b ack=%b gpio_o=%h oe=%h want 0",
               cs, ack, gpio_out, gpio_oe);
    end
    bus(1'b0, 3'd5, 64'd0, a, r);
    n_cmp++;
    if (a !== 1'b1 || r !== 64'd0) begin
      n_bad++;
      $display("FAIL cs_count_after_reset: ack=%b count=%0d want 1/0", a, r);
    end
  endtask

  task automatic test_back_to_back();
    int   acks;
    logic prev;
    logic exp;
    acks = 0;
    prev = 1'b0;
    stb = 1'b1; we = 1'b0; addr = 3'd0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      exp = (j % 2 == 0);
      if (ack === 1'b1) acks++;
      n_cmp++;
      if (ack !== exp || (ack === 1'b1 && prev === 1'b1) ||
          (ack === 1'b1 && rdata !== 64'h81)) begin
        n_bad++;
        $display("FAIL held_strobe j=%0d: ack=%b rdata=%h want ack=%b rdata=81",
                 j, ack, rdata, exp);
      end
      prev = ack;
    end
    stb = 1'b0;
    n_cmp++;
    if (acks != 3) begin
      n_bad++;
      $display("FAIL held_strobe_count: got %0d acks want 3", acks);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; gpio_in = '0;
    test_reset();
    test_dir_out();
    test_input_edge();
    test_random_regs();
    test_cs_pulse();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/as_gpio_port.md
# as_gpio_port

Memory-mapped GPIO controller for the rv64i SoC, placed between the core's data-bus decoder and the `gpio_io` pads of `as_top_mem`. It holds the GPIO ID, direction and output registers, synchronises pad inputs with sticky rising-edge capture, and generates the `cs_o` strobe that tells external hardware a GPIO value is valid. It is the device-side counterpart of the integration benches, which sample `gpio_io` while `cs_o` is high.

## Interface
Parameters:
- `nr_gpios`, 8, number of GPIO pins (1..64).
- `gpio_addr_width`, 3, register-select address width.
- `GPIO_ID`, 64'h81, constant returned by the ID register.

Ports:
- `clk_i`  in  1  system clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `stb_i`  in  1  bus transaction request.
- `we_i`  in  1  1 = write, 0 = read; sampled with `stb_i`.
- `addr_i`  in  `gpio_addr_width`  register select.
- `wdata_i`  in  64  write data.
- `rdata_o`  out  64  registered read data; valid while `ack_o` = 1.
- `ack_o`  out  1  one-cycle transaction acknowledge.
- `gpio_i`  in  `nr_gpios`  pad input values.
- `gpio_o`  out  `nr_gpios`  pad output values.
- `gpio_oe_o`  out  `nr_gpios`  pad output enables; 1 = drive.
- `cs_o`  out  1  chip-select / data-valid strobe.
- `irq_o`  out  1  OR of all sticky rise bits.

## Operation
Register map, by `addr_i`:
- 0 ID, read-only: `GPIO_ID`.
- 1 DIR, read/write: `[nr_gpios-1:0]`; drives `gpio_oe_o`.
- 2 OUT, read/write: drives `gpio_o`.
- 3 IN, read-only: synchronised `gpio_i`.
- 4 RISE, write-1-to-clear: sticky rising-edge flags.
- 5 CS, write `wdata_i[7:0]` = N: pulses `cs_o` for N cycles. Reads return the remaining count.
- 6, 7: reads return 0; writes are ignored.
- Unused upper read bits are 0. Write bits above `nr_gpios` are ignored.

Bus FSM has two states, IDLE and ACK:
- IDLE with `stb_i` = 1: perform the write, or latch the read data into `rdata_o`; go to ACK.
- ACK: `ack_o` = 1, then return to IDLE unconditionally.
- The master drops `stb_i` in the ACK cycle. A `stb_i` held high produces one transaction every 2 cycles.

Input path:
- Two-flop synchroniser `sync1` → `sync2`, plus a delayed copy `sync2_d`.
- `RISE[i]` is set when `sync2[i] & ~sync2_d[i]`.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.

CS generator:
- 8-bit down-counter `cs_cnt`; `cs_o` = (`cs_cnt` != 0).
- A write to CS loads N. This also applies while a pulse is active: the counter restarts with the new N.
- N = 0 stops any active pulse immediately.
- The counter decrements each cycle while non-zero and saturates at 0.

OUT writes take effect immediately, including during a CS pulse. Firmware writes OUT first, then CS.

## Timing
- Reset, held for one or more edges: `rdata_o`, `ack_o`, `cs_o`, `irq_o`, `gpio_o`, `gpio_oe_o`, DIR, OUT, RISE, `cs_cnt`, `sync1`, `sync2` and `sync2_d` are all 0; FSM is in IDLE. Reset wins over a simultaneous `stb_i`.
- Reset mid-transaction drops `ack_o` on the next edge. Reset mid-pulse drops `cs_o` on the next edge.
- Read latency: `stb_i` sampled at edge k → `ack_o` and `rdata_o` valid after edge k.
- Writes: the register updates at edge k. `gpio_o` and `gpio_oe_o` change after edge k, in the same cycle `ack_o` is high.
- CS write of N at edge k: `cs_o` is high after edges k .. k+N-1, i.e. exactly N cycles, low after edge k+N.
- Input: `gpio_i` change captured at edge k → IN readable from edge k+1 (`sync2`) → RISE bit and `irq_o` set after edge k+2.
- A read of IN or RISE returns the value present at the sampling edge k.

## Test plan
- Reset: hold `rst_i` for 10 cycles with `stb_i` toggling → all outputs 0, no `ack_o`; read ID → `rdata_o` = 0x81, `ack_o` exactly one cycle, 1 cycle after `stb_i`.
- DIR/OUT: write DIR = 0x7F, OUT = 0x1FF (`nr_gpios` = 8) → `gpio_oe_o` = 0x7F, `gpio_o` = 0xFF; readback DIR = 0x7F, OUT = 0xFF; read addr 6 → 0.
- Input and edge: drive `gpio_i[7]` 0→1 at edge k → IN bit 7 = 1 on a read at k+1 or later; RISE = 0x80 and `irq_o` = 1 after k+2. W1C 0x80 → RISE = 0. Repeat with a W1C in the same cycle as a new edge → bit stays 1.
- CS pulse: OUT = 0x81, then CS = 3 → `cs_o` high exactly 3 cycles with `gpio_o` = 0x81 throughout. CS = 0 → no pulse. CS = 5, then CS = 2 after 2 cycles → 4 high cycles total.
- Reset mid-pulse: CS = 200, assert `rst_i` 10 cycles later → `cs_o` = 0 after the next edge; remaining-count read after reset → 0.
- Held strobe: `stb_i` held high for 6 cycles of reads → exactly 3 `ack_o` pulses, never on consecutive cycles.
